// File: rtl/cla_seq_pkg.sv
// ---------------------------------------------------------------------------
// cla_seq_pkg : shared types and constants for the byte-serial CLA sequencer
// Revision 1.0
// ---------------------------------------------------------------------------
`default_nettype none

package cla_seq_pkg;

  localparam int BYTE_W = 8;

  localparam logic OP_ADD = 1'b0;
  localparam logic OP_SUB = 1'b1;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  // Signed overflow: operands agree in sign but the sum does not.
  function automatic logic add_overflow(input logic a_msb, input logic b_msb, input logic s_msb);
    return (a_msb == b_msb) && (s_msb != a_msb);
  endfunction

endpackage

`default_nettype wire

// File: rtl/cla8.sv
// ---------------------------------------------------------------------------
// cla8 : purely combinational 8-bit carry-lookahead adder
// Revision 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module cla8
  import cla_seq_pkg::*;
(
  input  logic [BYTE_W-1:0] dataA,
  input  logic [BYTE_W-1:0] dataB,
  input  logic              carryIn,
  output logic [BYTE_W-1:0] dataOut,
  output logic              carryOut
);

  logic [BYTE_W-1:0] gen;
  logic [BYTE_W-1:0] prop;
  logic [BYTE_W:0]   carry;
  logic              acc;
  logic              chain;

  // Each carry is the flat OR of generate terms gated by the propagate run above them.
  always_comb begin
    gen   = dataA & dataB;
    prop  = dataA ^ dataB;
    carry = '0;
    acc   = 1'b0;
    chain = 1'b1;
    for (int i = 0; i <= BYTE_W; i++) begin
      acc   = 1'b0;
      chain = 1'b1;
      for (int j = i - 1; j >= 0; j--) begin
        acc   = acc | (chain & gen[j]);
        chain = chain & prop[j];
      end
      carry[i] = acc | (chain & carryIn);
    end
    dataOut  = prop ^ carry[BYTE_W-1:0];
    carryOut = carry[BYTE_W];
  end

endmodule

`default_nettype wire

// File: rtl/cla_word_sequencer.sv
// ---------------------------------------------------------------------------
// cla_word_sequencer : word add/sub built by running one cla8 over the bytes
// Revision 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module cla_word_sequencer
  import cla_seq_pkg::*;
#(
  parameter int NBYTES = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  inValid,
  output logic                  inReady,
  input  logic [8*NBYTES-1:0]   dataA,
  input  logic [8*NBYTES-1:0]   dataB,
  input  logic                  opSub,
  input  logic                  carryIn,
  output logic                  outValid,
  input  logic                  outReady,
  output logic [8*NBYTES-1:0]   dataOut,
  output logic                  carryOut,
  output logic                  overflow,
  output logic                  zero
);

  localparam int WORD_W = BYTE_W * NBYTES;
  localparam int IDX_W  = (NBYTES > 1) ? $clog2(NBYTES) : 1;

  state_t            state;
  state_t            state_next;
  logic [IDX_W-1:0]  idx;
  logic [WORD_W-1:0] op_a;
  logic [WORD_W-1:0] op_b;
  logic              carry;
  logic [BYTE_W-1:0] byte_a;
  logic [BYTE_W-1:0] byte_b;
  logic [BYTE_W-1:0] byte_sum;
  logic              byte_cout;
  logic [WORD_W-1:0] result_next;
  logic              last_byte;
  logic              accept;
  int                base;

  always_comb begin
    base        = BYTE_W * int'(idx);
    byte_a      = op_a[base +: BYTE_W];
    byte_b      = op_b[base +: BYTE_W];
    result_next = dataOut;
    result_next[base +: BYTE_W] = byte_sum;
  end

  assign last_byte = (idx == IDX_W'(NBYTES - 1));
  assign accept    = (state == IDLE) && inValid;

  cla8 u_cla8 (
    .dataA   (byte_a),
    .dataB   (byte_b),
    .carryIn (carry),
    .dataOut (byte_sum),
    .carryOut(byte_cout)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_next;
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (inValid)   state_next = RUN;
      RUN:     if (last_byte) state_next = DONE;
      DONE:    if (outReady)  state_next = IDLE;
      default:                state_next = IDLE;
    endcase
  end

  assign inReady  = (state == IDLE);
  assign outValid = (state == DONE);

  // Subtraction is A + ~B + 1, so B is inverted once at accept time.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      idx      <= '0;
      op_a     <= '0;
      op_b     <= '0;
      carry    <= 1'b0;
      dataOut  <= '0;
      carryOut <= 1'b0;
      overflow <= 1'b0;
      zero     <= 1'b0;
    end else if (accept) begin
      idx   <= '0;
      op_a  <= dataA;
      op_b  <= (opSub == OP_SUB) ? ~dataB : dataB;
      carry <= (opSub == OP_SUB) ? 1'b1 : carryIn;
    end else if (state == RUN) begin
      dataOut <= result_next;
      carry   <= byte_cout;
      if (last_byte) begin
        carryOut <= byte_cout;
        overflow <= add_overflow(op_a[WORD_W-1], op_b[WORD_W-1], byte_sum[BYTE_W-1]);
        zero     <= (result_next == '0);
      end else begin
        idx <= idx + 1'b1;
      end
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_cla_word_sequencer.sv
// ---------------------------------------------------------------------------
// tb_cla_word_sequencer : directed and random checks against an arithmetic model
// Revision 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module tb_cla_word_sequencer;

  localparam int NBYTES = 4;
  localparam int W      = 8 * NBYTES;
  localparam longint MAXS = (longint'(1) <<< (W - 1)) - 1;
  localparam longint MINS = -(longint'(1) <<< (W - 1));

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         inValid = 1'b0;
  logic         inReady;
  logic [W-1:0] dataA = '0;
  logic [W-1:0] dataB = '0;
  logic         opSub = 1'b0;
  logic         carryIn = 1'b0;
  logic         outValid;
  logic         outReady = 1'b0;
  logic [W-1:0] dataOut;
  logic         carryOut;
  logic         overflow;
  logic         zero;

  int tests  = 0;
  int failed = 0;

  logic [W-1:0] exp_r;
  logic         exp_co, exp_ov, exp_z;
  logic         prev_co = 1'b0, prev_ov = 1'b0, prev_z = 1'b0;

  always #5 clk = ~clk;

  cla_word_sequencer #(.NBYTES(NBYTES)) dut (
    .clk     (clk),
    .rst     (rst),
    .inValid (inValid),
    .inReady (inReady),
    .dataA   (dataA),
    .dataB   (dataB),
    .opSub   (opSub),
    .carryIn (carryIn),
    .outValid(outValid),
    .outReady(outReady),
    .dataOut (dataOut),
    .carryOut(carryOut),
    .overflow(overflow),
    .zero    (zero)
  );

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    tests++;
    assert (obs === exp) else begin
      failed++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Reference: plain integer arithmetic on the whole word.
  task automatic model(input logic [W-1:0] a, input logic [W-1:0] b, input logic sub, input logic cin);
    longint sa, sb, sr;
    logic [W:0] full;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    if (sub) begin
      exp_r  = a - b;
      exp_co = (a >= b);
      sr     = sa - sb;
    end else begin
      full   = {1'b0, a} + {1'b0, b} + {{W{1'b0}}, cin};
      exp_r  = full[W-1:0];
      exp_co = full[W];
      sr     = sa + sb + longint'(cin);
    end
    exp_ov = (sr > MAXS) || (sr < MINS);
    exp_z  = (exp_r == '0);
  endtask

  task automatic start_op(input logic [W-1:0] a, input logic [W-1:0] b, input logic sub, input logic cin);
    check("ready_before_request", {63'd0, inReady}, 64'd1);
    model(a, b, sub, cin);
    dataA = a; dataB = b; opSub = sub; carryIn = cin; inValid = 1'b1;
    @(posedge clk); #1;
    inValid = 1'b0;
    dataA   = W'($urandom);
    dataB   = W'($urandom);
    opSub   = 1'($urandom_range(0, 1));
    carryIn = 1'($urandom_range(0, 1));
  endtask

  task automatic wait_done(input string tag);
    int edges;
    edges = 1;
    while (outValid !== 1'b1 && edges < 20) begin
      check({tag, "_flags_hold"}, {61'd0, carryOut, overflow, zero}, {61'd0, prev_co, prev_ov, prev_z});
      check({tag, "_busy"}, {63'd0, inReady}, 64'd0);
      @(posedge clk); #1;
      edges++;
    end
    check({tag, "_latency"}, 64'(edges), 64'(NBYTES + 1));
  endtask

  task automatic check_result(input string tag);
    check({tag, "_data"},  64'(dataOut),  64'(exp_r));
    check({tag, "_carry"}, {63'd0, carryOut}, {63'd0, exp_co});
    check({tag, "_ovf"},   {63'd0, overflow}, {63'd0, exp_ov});
    check({tag, "_zero"},  {63'd0, zero},     {63'd0, exp_z});
    prev_co = exp_co; prev_ov = exp_ov; prev_z = exp_z;
  endtask

  task automatic consume(input string tag);
    outReady = 1'b1;
    @(posedge clk); #1;
    outReady = 1'b0;
    check({tag, "_idle_after"}, {62'd0, inReady, outValid}, {62'd0, 1'b1, 1'b0});
  endtask

  task automatic run_op(input string tag, input logic [W-1:0] a, input logic [W-1:0] b, input logic sub, input logic cin);
    start_op(a, b, sub, cin);
    wait_done(tag);
    check_result(tag);
    consume(tag);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    logic [W-1:0] a, b;
    logic         s, c;

    repeat (2) @(posedge clk);
    #1;
    check("reset_outputs", {59'd0, inReady, outValid, carryOut, overflow, zero}, {59'd0, 5'b10000});
    check("reset_data", 64'(dataOut), 64'd0);
    @(negedge clk) rst = 1'b0;
    @(posedge clk); #1;

    run_op("add_1_2_cin", 32'h0000_0001, 32'h0000_0002, 1'b0, 1'b1);
    run_op("add_wrap",    32'hFFFF_FFFF, 32'h0000_0001, 1'b0, 1'b0);
    run_op("add_ovf",     32'h7FFF_FFFF, 32'h0000_0001, 1'b0, 1'b0);
    run_op("sub_borrow",  32'h0000_0005, 32'h0000_0006, 1'b1, 1'b0);
    run_op("sub_ovf",     32'h8000_0000, 32'h0000_0001, 1'b1, 1'b1);

    // Backpressure: result must hold while inValid pulses are ignored.
    start_op(32'h1234_5678, 32'h0FED_CBA9, 1'b0, 1'b1);
    wait_done("bp");
    check_result("bp");
    for (int k = 0; k < 10; k++) begin
      inValid = k[0];
      dataA   = W'($urandom);
      dataB   = W'($urandom);
      @(posedge clk); #1;
      check("bp_hold_data", 64'(dataOut), 64'(exp_r));
      check("bp_hold_flags", {60'd0, inReady, outValid, carryOut, overflow}, {60'd0, 1'b0, 1'b1, exp_co, exp_ov});
    end
    inValid  = 1'b1;
    outReady = 1'b1;
    @(posedge clk); #1;
    inValid  = 1'b0;
    outReady = 1'b0;
    check("bp_no_same_edge_accept", {62'd0, inReady, outValid}, {62'd0, 1'b1, 1'b0});

    // Reset two RUN edges into an operation.
    start_op(32'hA5A5_A5A5, 32'h5A5A_5A5B, 1'b0, 1'b0);
    @(posedge clk); @(posedge clk); #2;
    rst = 1'b1;
    #1;
    check("midrun_reset_outputs", {59'd0, inReady, outValid, carryOut, overflow, zero}, {59'd0, 5'b10000});
    check("midrun_reset_data", 64'(dataOut), 64'd0);
    prev_co = 1'b0; prev_ov = 1'b0; prev_z = 1'b0;
    @(negedge clk) rst = 1'b0;
    @(posedge clk); #1;
    run_op("after_reset", 32'h0000_00FF, 32'h0000_0001, 1'b0, 1'b0);

    for (int n = 0; n < 40; n++) begin
      a = W'($urandom);
      b = W'($urandom);
      case ($urandom_range(0, 3))
        0: b = ~a;
        1: b = a;
        2: a = {1'b0, {(W-1){1'b1}}};
        default: ;
      endcase
      s = 1'($urandom_range(0, 1));
      c = 1'($urandom_range(0, 1));
      run_op("random", a, b, s, c);
    end

    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

endmodule

`default_nettype wire
